// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - parametrised serial packet receiver for the serial ALU family
// Purpose: deserialises 11-bit frames (start, type, 8 payload MSB first, stop) from sin,
//          assembles NB DATA frames of B, NB DATA frames of A and one CMD frame into a
//          result, checks framing/length/CRC/opcode and presents it through a 1-deep
//          output stage.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sin        serial input, idle high
//   out_valid  result held in output stage
//   out_ready  consumer accepts result
//   a_o, b_o   operands (zero when the packet had the wrong number of DATA frames)
//   op_o       opcode
//   err_o      one-hot {FRAME, DATA, CRC, OP}, 0 = good packet
//   overrun_o  one-cycle pulse: a completed packet was dropped (output stage full)
module alu_serial_rx #(
    parameter int DATA_W = 32,
    parameter bit CRC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [2:0]        op_o,
    output logic [3:0]        err_o,
    output logic              overrun_o
);
    localparam int NB = DATA_W / 8;
    localparam int SW = 2 * DATA_W;
    localparam int CW = $clog2(2 * NB + 2);
    localparam logic [CW-1:0] DCNT_FULL = CW'(2 * NB);
    localparam logic [CW-1:0] DCNT_SAT  = CW'(2 * NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAY, S_STOP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic              type_q, type_d;
    logic [7:0]        pay_q, pay_d;
    logic [SW-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]     dcnt_q, dcnt_d;
    logic              ferr_q, ferr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        err_q, err_d;
    logic              ovr_q, ovr_d;
    logic [3:0]        pkt_err;
    logic [3:0]        crc_calc;

    // CRC-4, x^4+x+1, init 0, MSB first over {B, A, 1'b1, op}
    function automatic logic [3:0] crc4(input logic [SW+3:0] bits);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = SW + 3; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            type_q  <= 1'b0;
            pay_q   <= '0;
            shreg_q <= '0;
            dcnt_q  <= '0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            err_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            type_q  <= type_d;
            pay_q   <= pay_d;
            shreg_q <= shreg_d;
            dcnt_q  <= dcnt_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        type_d   = type_q;
        pay_d    = pay_q;
        shreg_d  = shreg_q;
        dcnt_d   = dcnt_q;
        ferr_d   = ferr_q;
        valid_d  = valid_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        err_d    = err_q;
        ovr_d    = 1'b0;
        pkt_err  = 4'b0000;
        crc_calc = crc4({shreg_q, 1'b1, pay_q[6:4]});

        unique case (state_q)
            S_IDLE: if (!sin) state_d = S_TYPE;
            S_TYPE: begin
                type_d  = sin;
                bcnt_d  = 3'd0;
                state_d = S_PAY;
            end
            S_PAY: begin
                pay_d  = {pay_q[6:0], sin};
                bcnt_d = bcnt_q + 3'd1;
                if (bcnt_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (valid_q && out_ready) valid_d = 1'b0;

        // stop-bit cycle: pay_q already holds the complete payload
        if (state_q == S_STOP) begin
            if (!type_q) begin
                if (sin) begin
                    shreg_d = {shreg_q[SW-9:0], pay_q};
                    if (dcnt_q != DCNT_SAT) dcnt_d = dcnt_q + CW'(1);
                end else begin
                    // bad stop: remember it, but keep receiving until the CMD frame
                    ferr_d = 1'b1;
                end
            end else begin
                if (ferr_q || !sin)                            pkt_err = 4'b1000;
                else if (dcnt_q != DCNT_FULL)                  pkt_err = 4'b0100;
                else if (CRC_EN && (crc_calc != pay_q[3:0]))   pkt_err = 4'b0010;
                else if (pay_q[5])                             pkt_err = 4'b0001; // op[1] set: 010,011,110,111

                // accept when empty or when the held result leaves this same cycle
                if (!valid_q || out_ready) begin
                    valid_d = 1'b1;
                    a_d     = pkt_err[2] ? '0 : shreg_q[DATA_W-1:0];
                    b_d     = pkt_err[2] ? '0 : shreg_q[SW-1:DATA_W];
                    op_d    = pay_q[6:4];
                    err_d   = pkt_err;
                end else begin
                    ovr_d = 1'b1;
                end
                shreg_d = '0;
                dcnt_d  = '0;
                ferr_d  = 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign op_o      = op_q;
    assign err_o     = err_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - scoreboard testbench for alu_serial_rx (32-bit CRC on, 8-bit CRC off)
module tb_alu_serial_rx;
    logic        clk = 1'b0;
    logic        rst, sin0, sin1, rdy;
    logic        v0, v1, ov0, ov1;
    logic [31:0] a0, b0;
    logic [7:0]  a1, b1;
    logic [2:0]  op0, op1;
    logic [3:0]  e0, e1;

    always #5 clk = ~clk;

    alu_serial_rx #(.DATA_W(32), .CRC_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .sin(sin0), .out_valid(v0), .out_ready(rdy),
        .a_o(a0), .b_o(b0), .op_o(op0), .err_o(e0), .overrun_o(ov0));
    alu_serial_rx #(.DATA_W(8), .CRC_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .sin(sin1), .out_valid(v1), .out_ready(rdy),
        .a_o(a1), .b_o(b1), .op_o(op1), .err_o(e1), .overrun_o(ov1));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  err;
    } exp_t;

    exp_t        sbq0[$], sbq1[$];
    int          n_cmp = 0, n_bad = 0;
    int          ovr_seen[2], exp_ovr[2];
    bit          f_typ[$], f_stop[$];
    logic [7:0]  f_pay[$];
    bit          rr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // remainder of ({B,A,1,op} * x^4) mod (x^4+x+1) by long division
    function automatic logic [3:0] crc_ref(input logic [63:0] ab, input logic [2:0] op);
        logic [79:0] m;
        m = {8'b0, ab, 1'b1, op, 4'b0000};
        for (int i = 79; i >= 4; i--)
            if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
        return m[3:0];
    endfunction

    // expected result of the packet currently described by f_typ/f_pay/f_stop
    function automatic exp_t model(input int nb, input bit crc_en);
        exp_t        x;
        logic [63:0] ab, msk;
        int          cnt;
        bit          ferr;
        logic [2:0]  op;
        logic [3:0]  crc_rx;
        ab = 0; cnt = 0; ferr = 0; op = 0; crc_rx = 0;
        msk = (64'd1 << (16 * nb)) - 64'd1;
        foreach (f_typ[i]) begin
            if (!f_typ[i]) begin
                if (f_stop[i]) begin
                    ab = ((ab << 8) | {56'b0, f_pay[i]}) & msk;
                    cnt++;
                end else ferr = 1'b1;
            end else begin
                if (!f_stop[i]) ferr = 1'b1;
                op     = f_pay[i][6:4];
                crc_rx = f_pay[i][3:0];
            end
        end
        x.b  = 32'(ab >> (8 * nb));
        x.a  = 32'(ab & ((64'd1 << (8 * nb)) - 64'd1));
        x.op = op;
        if (ferr)                                         x.err = 4'd8;
        else if (cnt != 2 * nb)                           x.err = 4'd4;
        else if (crc_en && crc_rx != crc_ref(ab, op))     x.err = 4'd2;
        else if (op inside {3'd2, 3'd3, 3'd6, 3'd7})      x.err = 4'd1;
        else                                              x.err = 4'd0;
        if (x.err == 4'd4) begin
            x.a = 0;
            x.b = 0;
        end
        return x;
    endfunction

    task automatic mon(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] e);
        exp_t x;
        int   sz;
        if (!v) return;
        sz = (k == 0) ? sbq0.size() : sbq1.size();
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 expected no pending result", k);
            return;
        end
        x = (k == 0) ? sbq0[0] : sbq1[0];
        chk($sformatf("a dut%0d", k), a, x.a);
        chk($sformatf("b dut%0d", k), b, x.b);
        chk($sformatf("op dut%0d", k), 32'(op), 32'(x.op));
        chk($sformatf("err dut%0d", k), 32'(e), 32'(x.err));
        if (rdy) begin
            if (k == 0) void'(sbq0.pop_front());
            else        void'(sbq1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, v0, a0, b0, op0, e0);
            mon(1, v1, {24'b0, a1}, {24'b0, b1}, op1, e1);
            if (ov0) ovr_seen[0]++;
            if (ov1) ovr_seen[1]++;
        end
    end

    task automatic drive_bit(input int k, input bit b);
        @(posedge clk);
        #1;
        if (k == 0) sin0 = b;
        else        sin1 = b;
    endtask

    task automatic send_frame(input int k, input bit typ, input logic [7:0] pay, input bit stp);
        drive_bit(k, 1'b0);
        drive_bit(k, typ);
        for (int i = 7; i >= 0; i--) drive_bit(k, pay[i]);
        drive_bit(k, stp);
    endtask

    // ndata DATA frames taken from the low bytes of ab (last frame = ab[7:0]), then CMD
    task automatic build(input int ndata, input logic [63:0] ab, input logic [2:0] op,
                         input logic [3:0] crc, input int bad_frame);
        logic [7:0] byt;
        for (int i = 0; i < ndata; i++) begin
            if (8 * (ndata - 1 - i) < 64) byt = 8'(ab >> (8 * (ndata - 1 - i)));
            else                          byt = 8'($urandom);
            f_typ.push_back(1'b0);
            f_pay.push_back(byt);
            f_stop.push_back(i != bad_frame);
        end
        f_typ.push_back(1'b1);
        f_pay.push_back({1'b0, op, crc});
        f_stop.push_back(ndata != bad_frame);
    endtask

    // returns one cycle after the CMD stop bit has been sampled
    task automatic send_pkt(input int k, input bit drop);
        exp_t x;
        x = model((k == 0) ? 4 : 1, k == 0);
        if (drop)        exp_ovr[k]++;
        else if (k == 0) sbq0.push_back(x);
        else             sbq1.push_back(x);
        foreach (f_typ[i]) send_frame(k, f_typ[i], f_pay[i], f_stop[i]);
        drive_bit(k, 1'b1);
        f_typ.delete();
        f_pay.delete();
        f_stop.delete();
    endtask

    task automatic expect_now(input int k, input string name, input logic [3:0] err);
        chk({name, " valid"}, 32'(k == 0 ? v0 : v1), 32'd1);
        chk({name, " err"}, 32'(k == 0 ? e0 : e1), 32'(err));
        @(posedge clk);
        #1;
        chk({name, " valid next"}, 32'(k == 0 ? v0 : v1), 32'd0);
    endtask

    function automatic logic [63:0] rnd_ab(input int nb);
        return {$urandom, $urandom} & ((64'd1 << (16 * nb)) - 64'd1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] ab;
        logic [2:0]  op;
        rst = 1'b1; sin0 = 1'b1; sin1 = 1'b1; rdy = 1'b1;
        ovr_seen[0] = 0; ovr_seen[1] = 0; exp_ovr[0] = 0; exp_ovr[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid0", 32'(v0), 0);
        chk("reset a0", a0, 0);
        chk("reset b0", b0, 0);
        chk("reset err0", 32'(e0), 0);
        chk("reset ovr0", 32'(ov0), 0);
        chk("reset valid1", 32'(v1), 0);
        rst = 1'b0;

        // zero operands, AND, correct CRC 0xB
        build(8, 64'd0, 3'd0, 4'hB, -1); send_pkt(0, 0); expect_now(0, "t1", 4'b0000);
        build(8, 64'd0, 3'd0, 4'hA, -1); send_pkt(0, 0); expect_now(0, "t2 crc", 4'b0010);
        build(2, 64'd0, 3'd0, 4'hA, -1); send_pkt(1, 0); expect_now(1, "t2 crc off", 4'b0000);
        build(8, 64'd0, 3'd2, 4'hD, -1); send_pkt(0, 0); expect_now(0, "t3 op", 4'b0001);
        ab = rnd_ab(4);
        build(7, ab, 3'd0, 4'hB, -1); send_pkt(0, 0);
        chk("t4 a zero", a0, 0);
        expect_now(0, "t4 short", 4'b0100);
        ab = rnd_ab(4);
        build(8, ab, 3'd4, crc_ref(ab, 3'd4), -1); send_pkt(0, 0); expect_now(0, "t4 recover", 4'b0000);
        ab = rnd_ab(4);
        build(10, ab, 3'd5, crc_ref(ab, 3'd5), -1); send_pkt(0, 0); expect_now(0, "saturate", 4'b0100);

        // output stage full: second packet is dropped, first held
        rdy = 1'b0;
        ab = rnd_ab(4); op = 3'($urandom);
        build(8, ab, op, crc_ref(ab, op), -1); send_pkt(0, 0);
        ab = rnd_ab(4); op = 3'($urandom);
        build(8, ab, op, crc_ref(ab, op), -1); send_pkt(0, 1);
        @(posedge clk);
        #1;
        chk("t5 still valid", 32'(v0), 1);
        chk("t5 overrun count", 32'(ovr_seen[0]), 1);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 valid after transfer", 32'(v0), 0);

        ab = rnd_ab(4);
        build(8, ab, 3'd1, crc_ref(ab, 3'd1), 2); send_pkt(0, 0); expect_now(0, "t6 frame", 4'b1000);
        ab = rnd_ab(4);
        build(8, ab, 3'd1, crc_ref(ab, 3'd1), 8); send_pkt(0, 0); expect_now(0, "cmd frame", 4'b1000);

        // asynchronous reset with a held result and a partial packet in flight
        rdy = 1'b0;
        ab = rnd_ab(4) | 64'h1;
        build(8, ab, 3'd4, crc_ref(ab, 3'd4), -1); send_pkt(0, 0);
        chk("pre-reset valid", 32'(v0), 1);
        for (int i = 0; i < 3; i++) send_frame(0, 1'b0, 8'($urandom), 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(v0), 0);
        chk("async rst a", a0, 0);
        chk("async rst b", b0, 0);
        chk("async rst op", 32'(op0), 0);
        chk("async rst err", 32'(e0), 0);
        sbq0.delete();
        sin0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
        ab = rnd_ab(4);
        build(8, ab, 3'd5, crc_ref(ab, 3'd5), -1); send_pkt(0, 0); expect_now(0, "post reset", 4'b0000);

        build(2, 64'd0, 3'd0, 4'hB, -1); send_pkt(1, 0); expect_now(1, "t1 w8", 4'b0000);

        // randomized packets with random consumer back-pressure
        rr = 1'b1;
        fork
            while (rr) begin
                @(posedge clk);
                #1;
                rdy = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int n = 0; n < 30; n++) begin
            int k, nb, nd, bad, r;
            logic [3:0] crc;
            k  = n % 2;
            nb = (k == 0) ? 4 : 1;
            r  = $urandom_range(0, 9);
            nd = (r == 0) ? 2 * nb - 1 : (r == 1) ? 2 * nb + 1 : 2 * nb;
            bad = (r == 2) ? $urandom_range(0, nd) : -1;
            ab = rnd_ab(nb);
            op = 3'($urandom);
            crc = (r == 3) ? 4'($urandom) : crc_ref(ab, op);
            build(nd, ab, op, crc, bad);
            send_pkt(k, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rr = 1'b0;
        @(posedge clk);
        #2;
        rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("overrun total dut0", 32'(ovr_seen[0]), 32'(exp_ovr[0]));
        chk("overrun total dut1", 32'(ovr_seen[1]), 32'(exp_ovr[1]));
        chk("pending dut0", 32'(sbq0.size()), 0);
        chk("pending dut1", 32'(sbq1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
